// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: arctangent table, quarter-turn constant and
// the sequencing states of the iterative vectoring unit.
package cordic_pkg;

  localparam int ATAN_N = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // atan(2^-i) scaled so that 2^32 is one full turn; narrower angles are rounded from this.
  localparam logic [31:0] ATAN_TAB [0:ATAN_N-1] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  function automatic logic [31:0] atan_entry(input int idx, input int aw);
    logic [32:0] t;
    int          sh;
    t  = {1'b0, ATAN_TAB[idx]};
    sh = 32 - aw;
    if (sh > 0) begin
      t = t + (33'd1 << (sh - 1));
      t = t >> sh;
    end
    return t[31:0];
  endfunction

  // +90 degrees for a given angle width.
  function automatic longint ang_90(input int aw);
    return longint'(64'd1 << (aw - 2));
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, index i -> round(atan(2^-i) * 2^(ANGLE_W-1)/pi).
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = 16
) (
  input  logic        [CNT_W-1:0]   i_idx,
  output logic signed [ANGLE_W-1:0] o_atan
);

  always_comb begin
    o_atan = ANGLE_W'(atan_entry(int'(i_idx), ANGLE_W));
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: rotates (x,y) onto the +x axis, returning
// the uncompensated magnitude (x*K) and the saturated angle atan2(y,x).
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ANGLE_W = 16,
  parameter int ITER    = 12
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   x_in,
  input  logic signed [WIDTH-1:0]   y_in,
  output logic                      busy,
  output logic                      done,
  output logic        [WIDTH+1:0]   mag_out,
  output logic signed [ANGLE_W-1:0] angle_out
);

  localparam int XW = WIDTH + 2;
  localparam int ZW = ANGLE_W + 1;
  localparam logic signed [ZW-1:0] Z_P90 = ZW'(ang_90(ANGLE_W));

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic signed [XW-1:0]        r_x;
  logic signed [XW-1:0]        r_y;
  logic signed [ZW-1:0]        r_z;
  logic        [CNT_W-1:0]     r_iter;
  logic                        r_done;
  logic        [XW-1:0]        r_mag;
  logic signed [ANGLE_W-1:0]   r_ang;
  logic                        w_accept;
  logic                        w_last;
  logic signed [ANGLE_W-1:0]   w_atan;
  logic signed [ZW-1:0]        w_atan_z;
  logic signed [XW-1:0]        w_x_sh;
  logic signed [XW-1:0]        w_y_sh;

  function automatic logic signed [ANGLE_W-1:0] sat_angle(input logic signed [ZW-1:0] z);
    if (z[ZW-1] == z[ZW-2]) return z[ANGLE_W-1:0];
    else if (!z[ZW-1])      return {1'b0, {(ANGLE_W-1){1'b1}}};
    else                    return {1'b1, {(ANGLE_W-1){1'b0}}};
  endfunction

  cordic_atan_rom #(.ANGLE_W(ANGLE_W)) u_atan_rom (
    .i_idx  (r_iter),
    .o_atan (w_atan)
  );

  // The cycle carrying the done pulse is already IDLE; a start there is deliberately dropped.
  assign w_accept = (r_state == S_IDLE) && start && !r_done;
  assign w_last   = (r_iter == CNT_W'(ITER - 1));
  assign w_atan_z = {w_atan[ANGLE_W-1], w_atan};
  assign w_x_sh   = r_x >>> r_iter;
  assign w_y_sh   = r_y >>> r_iter;

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign mag_out   = r_mag;
  assign angle_out = r_ang;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_PRE;
      S_PRE:  w_state_nxt = S_ITER;
      S_ITER: if (w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_iter <= '0;
      r_done <= 1'b0;
      r_mag  <= '0;
      r_ang  <= '0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x    <= {{2{x_in[WIDTH-1]}}, x_in};
            r_y    <= {{2{y_in[WIDTH-1]}}, y_in};
            r_z    <= '0;
            r_iter <= '0;
          end
        end
        S_PRE: begin
          // Fold left half-plane into the right half so the iterations converge.
          if (r_x < 0 && r_y >= 0) begin
            r_x <= r_y;
            r_y <= -r_x;
            r_z <= Z_P90;
          end else if (r_x < 0) begin
            r_x <= -r_y;
            r_y <= r_x;
            r_z <= -Z_P90;
          end else begin
            r_z <= '0;
          end
        end
        S_ITER: begin
          if (r_y >= 0) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan_z;
          end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan_z;
          end
          r_iter <= r_iter + 1'b1;
        end
        S_DONE: begin
          r_mag <= $unsigned(r_x);
          r_ang <= sat_angle(r_z);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed-vector bench for cordic_vectoring (WIDTH=16, ANGLE_W=16, ITER=12).
module tb_cordic_vectoring;

  logic               CLK;
  logic               RST;
  logic               start;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic               busy;
  logic               done;
  logic        [17:0] mag_out;
  logic signed [15:0] angle_out;

  int n_checks = 0;
  int n_errors = 0;

  cordic_vectoring #(.WIDTH(16), .ANGLE_W(16), .ITER(12)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .mag_out   (mag_out),
    .angle_out (angle_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input longint act, input longint exp, input longint tol);
    n_checks++;
    if (act < exp - tol || act > exp + tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, act, exp, tol);
    end
  endtask

  // Launch one operation and wait (bounded) for done; lat = cycles from start edge to done.
  task automatic launch(input logic signed [15:0] xv, input logic signed [15:0] yv, output int lat);
    @(negedge CLK);
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    lat   = 0;
    check("busy_after_start", busy, 1, 0);
    while (!done && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic do_vec(input string tag, input logic signed [15:0] xv, input logic signed [15:0] yv,
                        input longint eang, input longint atol, input longint emag, input longint mtol);
    int lat;
    launch(xv, yv, lat);
    check({tag, "_latency"}, lat, 14, 0);
    check({tag, "_busy_in_done"}, busy, 0, 0);
    check({tag, "_angle"}, angle_out, eang, atol);
    if (emag >= 0) check({tag, "_mag"}, mag_out, emag, mtol);
    // start held during the done cycle must be dropped
    start = 1'b1;
    x_in  = 16'sd5;
    y_in  = 16'sd5;
    @(posedge CLK);
    #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0, 0);
    check({tag, "_start_in_done_ignored"}, busy, 0, 0);
    check({tag, "_hold_angle"}, angle_out, eang, atol);
  endtask

  initial begin
    int lat;
    int n_done;
    RST   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    #12;
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_mag", mag_out, 0, 0);
    check("rst_angle", angle_out, 0, 0);
    @(negedge CLK);
    RST = 1'b0;

    do_vec("x1000_y0",     16'sd1000,  16'sd0,     0,      8, 1647,  4);
    do_vec("x1000_y1000",  16'sd1000,  16'sd1000,  8192,   8, 2329,  4);
    do_vec("x0_yn1000",    16'sd0,    -16'sd1000, -16384,  8, 1647,  4);
    do_vec("xn1000_y1000", -16'sd1000, 16'sd1000,  24576,  8, 2329,  4);
    do_vec("xn1000_y0",    -16'sd1000, 16'sd0,     32763,  4, 1647,  4);
    do_vec("zero",         16'sd0,     16'sd0,     0,  32767, 0,     0);
    do_vec("min_min",      -16'sd32768, -16'sd32768, -24576, 8, 76310, 16);

    // Second start during iterations must not be queued or disturb the first operand pair.
    @(negedge CLK);
    x_in  = 16'sd1000;
    y_in  = 16'sd1000;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    x_in  = -16'sd1000;
    y_in  = 16'sd0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (done) begin
        n_done++;
        check("busy_start_angle", angle_out, 8192, 8);
        check("busy_start_mag", mag_out, 2329, 4);
      end
    end
    check("busy_start_single_done", n_done, 1, 0);

    // Asynchronous reset in the middle of the iterations.
    @(negedge CLK);
    x_in  = 16'sd1000;
    y_in  = 16'sd0;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("midrst_mag", mag_out, 0, 0);
    check("midrst_angle", angle_out, 0, 0);
    check("midrst_busy", busy, 0, 0);
    check("midrst_done", done, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 0, 0);
    check("midrst_idle", busy, 0, 0);

    launch(16'sd1000, 16'sd1000, lat);
    check("after_rst_latency", lat, 14, 0);
    check("after_rst_angle", angle_out, 8192, 8);
    check("after_rst_mag", mag_out, 2329, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
